prog_bus_mach: RTL and testbench

// Program-bus machine for the Tiny DSP. Consumes the decoder's go_prog/read_prog

---
 rtl/prog_bus_mach.sv | 165 ++++++++++++++++
 tb/tb_prog_bus_mach.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_bus_mach.sv
// prog_bus_mach: program-bus sequencer for the Tiny DSP.
// Each instruction cycle it runs one phased program-memory access: a fetch from pc,
// a table read (TBLR), or a table write (TBLW). A fetched word appears on p_data_out
// in the phi_5 cycle and stays there until the next read captures.
module prog_bus_mach #(
  parameter int AW = 16,
  parameter int DW = 16,
  // Tiny DSP NOP opcode, presented to the decoder after reset and after an abort.
  parameter logic [DW-1:0] NOP_WORD = 16'h7F80
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          phi_1,
  input  logic          phi_2,
  input  logic          phi_3,
  input  logic          phi_4,
  input  logic          phi_5,
  input  logic          phi_6,
  input  logic          go_prog,
  input  logic          read_prog,
  input  logic [AW-1:0] pc,
  input  logic          tbl_sel,
  input  logic [AW-1:0] tbl_addr,
  input  logic          tbl_wr,
  input  logic [DW-1:0] tbl_wdata,
  input  logic [DW-1:0] prog_rdata,
  output logic [AW-1:0] prog_addr,
  output logic          prog_cs,
  output logic          prog_oe,
  output logic          prog_we,
  output logic [DW-1:0] prog_wdata,
  output logic [DW-1:0] p_data_out,
  output logic          prog_busy,
  output logic          prog_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    ACCESS  = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          is_wr_q, is_wr_d;   // current access is a TBLW
  logic [AW-1:0] addr_q, addr_d;
  logic          cs_q, cs_d;
  logic          oe_q, oe_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] pdata_q, pdata_d;
  logic          err_q, err_d;

  // phi_3 is an idle wait phase for the memory and phi_6 belongs to the decoder;
  // neither changes this block's state.
  logic unused_phases;
  assign unused_phases = phi_3 ^ phi_6;

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    cs_d    = cs_q;
    oe_d    = oe_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    pdata_d = pdata_q;
    err_d   = 1'b0;

    if (phi_1 && (state_q != IDLE)) begin
      // Phase slip: abandon the access and ignore this cycle's request.
      cs_d    = 1'b0;
      oe_d    = 1'b0;
      we_d    = 1'b0;
      state_d = IDLE;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (phi_1) begin
            if (go_prog && read_prog) begin
              // Read wins over a simultaneous table write; the write is dropped.
              addr_d  = tbl_sel ? tbl_addr : pc;
              cs_d    = 1'b1;
              is_wr_d = 1'b0;
              state_d = ADDR;
              err_d   = tbl_wr;
            end else if (go_prog) begin
              // A program-bus request that is not a read is illegal.
              err_d = 1'b1;
            end else if (tbl_wr) begin
              addr_d  = tbl_addr;
              wdata_d = tbl_wdata;
              cs_d    = 1'b1;
              is_wr_d = 1'b1;
              state_d = ADDR;
            end
          end
        end
        ADDR: begin
          if (phi_2) begin
            if (is_wr_q) we_d = 1'b1;
            else         oe_d = 1'b1;
            state_d = ACCESS;
          end
        end
        ACCESS: begin
          if (phi_4) begin
            if (!is_wr_q) pdata_d = prog_rdata;
            oe_d    = 1'b0;
            we_d    = 1'b0;
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (phi_5) begin
            cs_d    = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      cs_q    <= 1'b0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      pdata_q <= NOP_WORD;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      pdata_q <= pdata_d;
      err_q   <= err_d;
    end
  end

  assign prog_addr  = addr_q;
  assign prog_cs    = cs_q;
  assign prog_oe    = oe_q;
  assign prog_we    = we_q;
  assign prog_wdata = wdata_q;
  assign p_data_out = pdata_q;
  assign prog_err   = err_q;
  assign prog_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_prog_bus_mach.sv
// tb_prog_bus_mach: directed stimulus with a scoreboard. The stimulus pushes the
// expected bus transaction / error pulse; a monitor reconstructs each transaction
// from the memory strobes and compares it when chip select falls.
module tb_prog_bus_mach;

  localparam logic [15:0] NOP = 16'h7F80;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          ph = 1;
  logic        slip = 1'b0;
  logic        started = 1'b0;

  logic        phi_1, phi_2, phi_3, phi_4, phi_5, phi_6;
  logic        go_prog = 1'b0, read_prog = 1'b0, tbl_sel = 1'b0, tbl_wr = 1'b0;
  logic [15:0] pc = '0, tbl_addr = '0, tbl_wdata = '0;
  logic [15:0] prog_rdata;
  logic [15:0] prog_addr, prog_wdata, p_data_out;
  logic        prog_cs, prog_oe, prog_we, prog_busy, prog_err;

  logic [15:0] mem [0:511];

  typedef struct {
    string       name;
    logic [15:0] addr;
    int          oe_n;
    int          we_n;
    logic [15:0] pdata;
  } txn_t;

  txn_t  txn_q[$];
  string err_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int viol = 0, txn_seen = 0, err_seen = 0;

  prog_bus_mach dut (
    .clk(clk), .reset(reset),
    .phi_1(phi_1), .phi_2(phi_2), .phi_3(phi_3),
    .phi_4(phi_4), .phi_5(phi_5), .phi_6(phi_6),
    .go_prog(go_prog), .read_prog(read_prog), .pc(pc),
    .tbl_sel(tbl_sel), .tbl_addr(tbl_addr), .tbl_wr(tbl_wr), .tbl_wdata(tbl_wdata),
    .prog_rdata(prog_rdata), .prog_addr(prog_addr), .prog_cs(prog_cs),
    .prog_oe(prog_oe), .prog_we(prog_we), .prog_wdata(prog_wdata),
    .p_data_out(p_data_out), .prog_busy(prog_busy), .prog_err(prog_err)
  );

  initial forever #5 clk = ~clk;

  // Phase generator: advances on the falling edge; slip forces an early phi_1.
  initial forever begin
    @(negedge clk);
    ph = slip ? 1 : ((ph == 6) ? 1 : ph + 1);
  end

  assign phi_1 = (ph == 1);
  assign phi_2 = (ph == 2);
  assign phi_3 = (ph == 3);
  assign phi_4 = (ph == 4);
  assign phi_5 = (ph == 5);
  assign phi_6 = (ph == 6);

  // Program memory model: read data only while selected and enabled.
  assign prog_rdata = (prog_cs === 1'b1 && prog_oe === 1'b1) ? mem[prog_addr[8:0]] : 16'hDEAD;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    mem[9'h040] = 16'h2A05;
    mem[9'h041] = 16'h1111;
    mem[9'h042] = 16'h2222;
    mem[9'h043] = 16'h3333;
    mem[9'h100] = 16'hBEEF;
    forever begin
      @(posedge clk);
      if (prog_cs === 1'b1 && prog_we === 1'b1) mem[prog_addr[8:0]] <= prog_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic push_txn(input string name, input logic [15:0] addr, input int oe_n,
                          input int we_n, input logic [15:0] pdata);
    txn_t t;
    t.name = name; t.addr = addr; t.oe_n = oe_n; t.we_n = we_n; t.pdata = pdata;
    txn_q.push_back(t);
  endtask

  // Present a request during a phi_1 cycle; returns just after the phi_1 edge.
  task automatic issue(input logic go, input logic rd, input logic sel, input logic wr,
                       input logic [15:0] pc_v, input logic [15:0] ta, input logic [15:0] wd);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (ph != 6 && n < 20);
    if (ph != 6) fail_now("phase_wait", "phi_6 never seen");
    @(negedge clk);
    go_prog = go; read_prog = rd; tbl_sel = sel; tbl_wr = wr;
    pc = pc_v; tbl_addr = ta; tbl_wdata = wd;
    @(posedge clk);
    #1;
    go_prog = 1'b0; read_prog = 1'b0; tbl_sel = 1'b0; tbl_wr = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
  endtask

  // Monitor: sample one time unit after each rising edge.
  logic        cs_prev = 1'b0;
  logic [15:0] cur_addr = '0;
  int          oe_n = 0, we_n = 0;
  bit          moved = 1'b0;

  initial forever begin
    txn_t  t;
    string e;
    @(posedge clk);
    #1;
    if (started) begin
      if (prog_oe === 1'b1 && prog_we === 1'b1) viol++;
      if ((prog_oe === 1'b1 || prog_we === 1'b1) && prog_cs !== 1'b1) viol++;
      if (prog_busy !== prog_cs) viol++;
    end
    if (prog_err === 1'b1) begin
      err_seen++;
      if (err_q.size() == 0) fail_now("unexpected_err", "prog_err with nothing expected");
      else begin
        e = err_q.pop_front();
        check({"err_phase_", e}, ph, 1);
      end
    end
    if (prog_cs === 1'b1) begin
      if (!cs_prev) begin
        cur_addr = prog_addr; oe_n = 0; we_n = 0; moved = 1'b0;
      end else if (prog_addr !== cur_addr) moved = 1'b1;
      if (prog_oe === 1'b1) oe_n++;
      if (prog_we === 1'b1) we_n++;
    end else if (cs_prev) begin
      txn_seen++;
      if (txn_q.size() == 0) fail_now("unexpected_txn", "chip select cycle with nothing expected");
      else begin
        t = txn_q.pop_front();
        check({t.name, "_addr"},   cur_addr,   t.addr);
        check({t.name, "_oe_clk"}, oe_n,       t.oe_n);
        check({t.name, "_we_clk"}, we_n,       t.we_n);
        check({t.name, "_pdata"},  p_data_out, t.pdata);
        check({t.name, "_stable"}, moved,      0);
      end
    end
    cs_prev = (prog_cs === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    // Reset held three clocks starting mid-phase.
    while (ph != 2) @(posedge clk);
    @(negedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_pdata", p_data_out, NOP);
    check("rst_cs",    prog_cs,    0);
    check("rst_oe",    prog_oe,    0);
    check("rst_we",    prog_we,    0);
    check("rst_busy",  prog_busy,  0);
    check("rst_err",   prog_err,   0);
    check("rst_addr",  prog_addr,  0);
    check("rst_wdata", prog_wdata, 0);
    started = 1'b1;

    // Instruction fetch from pc.
    push_txn("fetch", 16'h0040, 2, 0, 16'h2A05);
    issue(1, 1, 0, 0, 16'h0040, 16'h0000, 16'h0000);
    settle();

    // TBLR: table address replaces pc.
    push_txn("tblr", 16'h0100, 2, 0, 16'hBEEF);
    issue(1, 1, 1, 0, 16'h0040, 16'h0100, 16'h0000);
    settle();

    // TBLW: write strobe only, fetched word held.
    push_txn("tblw", 16'h0102, 0, 2, 16'hBEEF);
    issue(0, 0, 0, 1, 16'h0040, 16'h0102, 16'h1234);
    settle();
    @(negedge clk);
    check("tblw_mem", mem[9'h102], 16'h1234);

    // Read plus table write: read runs, write dropped, error pulse.
    push_txn("conflict", 16'h0040, 2, 0, 16'h2A05);
    err_q.push_back("conflict");
    issue(1, 1, 0, 1, 16'h0040, 16'h0104, 16'h5555);
    settle();
    @(negedge clk);
    check("conflict_mem", mem[9'h104], 16'h0000);

    // Non-read program request: no access, error pulse.
    err_q.push_back("illegal");
    issue(1, 0, 0, 0, 16'h0041, 16'h0000, 16'h0000);
    settle();

    // Phase slip during ACCESS: strobes drop, data not captured, error pulse.
    push_txn("slip", 16'h0041, 1, 0, 16'h2A05);
    err_q.push_back("slip");
    issue(1, 1, 0, 0, 16'h0041, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    slip = 1'b1;
    @(posedge clk);
    #1;
    slip = 1'b0;
    settle();

    // Reset during the phi_3 clock of a read.
    push_txn("abort", 16'h0042, 1, 0, NOP);
    issue(1, 1, 0, 0, 16'h0042, 16'h0000, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_pdata", p_data_out, NOP);
    check("abort_cs",    prog_cs,    0);
    settle();

    // A fetch after the abort completes normally.
    push_txn("refetch", 16'h0043, 2, 0, 16'h3333);
    issue(1, 1, 0, 0, 16'h0043, 16'h0000, 16'h0000);
    settle();

    @(negedge clk);
    check("txn_left",   txn_q.size(), 0);
    check("err_left",   err_q.size(), 0);
    check("txn_count",  txn_seen,     7);
    check("err_count",  err_seen,     3);
    check("invariants", viol,         0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
